// File: rtl/complex_divider_pkg.sv
// Shared types and widths for the sequential complex divider.
// Quotient magnitudes never exceed the numerator operand, so QW = W+1 is enough.
package cplx_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_t;

    localparam int unsigned W_DEF   = 32;
    localparam int unsigned PW_DEF  = 2 * W_DEF + 1;
    localparam int unsigned QW_DEF  = W_DEF + 1;
    localparam int unsigned DIV_CYC = PW_DEF;

    function automatic int unsigned prod_width(input int unsigned w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/complex_divider_if.sv
// Operand/result handshake bundle for complex_divider.
// The slave side is the divider and the master side is the producer/consumer.
interface complex_divider_if
    import cplx_div_pkg::*;
#(
    parameter int unsigned W = W_DEF
) ();

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] nr;
    logic signed [W-1:0] ni;
    logic signed [W-1:0] dr;
    logic signed [W-1:0] di;
    logic                out_valid;
    logic                out_ready;
    logic signed [W:0]   qr;
    logic signed [W:0]   qi;
    logic                div_by_zero;

    modport slave (
        input  in_valid, nr, ni, dr, di, out_ready,
        output in_ready, out_valid, qr, qi, div_by_zero
    );

    modport master (
        output in_valid, nr, ni, dr, di, out_ready,
        input  in_ready, out_valid, qr, qi, div_by_zero
    );

endinterface

// File: rtl/complex_divider_udiv.sv
// Restoring unsigned divider, one quotient bit per cycle.
// The start edge already performs the first iteration, so done follows start by exactly N cycles.
module udiv_seq #(
    parameter int unsigned N = 65
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient
);

    localparam int unsigned CW = $clog2(N + 1);

    logic [N-1:0]  rem_q, quo_q, dvs_q;
    logic [N-1:0]  rem_src, quo_src, dvs_src;
    logic [N-1:0]  rem_nxt, quo_nxt;
    logic [N:0]    trial;
    logic          fits;
    logic [CW-1:0] cnt_q;

    always_comb begin
        rem_src = start ? '0 : rem_q;
        quo_src = start ? dividend : quo_q;
        dvs_src = start ? divisor : dvs_q;
        trial   = {rem_src, quo_src[N-1]};
        fits    = trial >= {1'b0, dvs_src};
        // the partial remainder is always below the divisor, so N bits hold it
        rem_nxt = fits ? N'(trial - {1'b0, dvs_src}) : trial[N-1:0];
        quo_nxt = {quo_src[N-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt_q <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                dvs_q <= dvs_src;
                cnt_q <= CW'(N - 1);
                busy  <= 1'b1;
            end else if (busy) begin
                rem_q <= rem_nxt;
                quo_q <= quo_nxt;
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign quotient = quo_q;

endmodule

// File: rtl/complex_divider.sv
// Sequential signed complex divider q = n / d, each component truncated toward zero.
// Cross products are formed once, then two restoring dividers run in parallel on magnitudes.
module complex_divider
    import cplx_div_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input logic               clk,
    input logic               rst,
    complex_divider_if.slave  bus
);

    localparam int unsigned PW = 2 * W + 1;
    localparam int unsigned QW = W + 1;

    state_t state_q, state_n;

    logic signed [W-1:0]  nr_q, ni_q, dr_q, di_q;
    logic signed [PW-1:0] nr_x, ni_x, dr_x, di_x;
    logic signed [PW-1:0] num_r_c, num_i_c;
    logic [PW-1:0]        den_c, mag_r, mag_i;
    logic [PW-1:0]        quo_r, quo_i, q_full_r, q_full_i;
    logic                 den_zero, accept, start, div_fin;
    logic                 busy_r, busy_i, done_r, done_i;
    logic                 neg_r_q, neg_i_q;
    logic signed [QW-1:0] qr_q, qi_q;
    logic                 dbz_q;

    always_comb begin
        nr_x     = PW'(nr_q);
        ni_x     = PW'(ni_q);
        dr_x     = PW'(dr_q);
        di_x     = PW'(di_q);
        num_r_c  = nr_x * dr_x + ni_x * di_x;
        num_i_c  = ni_x * dr_x - nr_x * di_x;
        den_c    = $unsigned(dr_x * dr_x + di_x * di_x);
        den_zero = den_c == '0;
        mag_r    = num_r_c[PW-1] ? $unsigned(-num_r_c) : $unsigned(num_r_c);
        mag_i    = num_i_c[PW-1] ? $unsigned(-num_i_c) : $unsigned(num_i_c);
        q_full_r = neg_r_q ? -quo_r : quo_r;
        q_full_i = neg_i_q ? -quo_i : quo_i;
        accept   = bus.in_valid && bus.in_ready;
        start    = (state_q == MULT) && !den_zero;
        div_fin  = done_r && done_i && !busy_r && !busy_i;
    end

    udiv_seq #(.N(PW)) u_div_r (
        .clk(clk), .rst(rst), .start(start),
        .dividend(mag_r), .divisor(den_c),
        .busy(busy_r), .done(done_r), .quotient(quo_r)
    );

    udiv_seq #(.N(PW)) u_div_i (
        .clk(clk), .rst(rst), .start(start),
        .dividend(mag_i), .divisor(den_c),
        .busy(busy_i), .done(done_i), .quotient(quo_i)
    );

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE: if (accept)        state_n = MULT;
            MULT: state_n = den_zero ? DONE : DIV;
            DIV:  if (div_fin)       state_n = DONE;
            DONE: if (bus.out_ready) state_n = IDLE;
            default:                 state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            qr_q    <= '0;
            qi_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            case (state_q)
                IDLE: if (accept) begin
                    nr_q <= bus.nr;
                    ni_q <= bus.ni;
                    dr_q <= bus.dr;
                    di_q <= bus.di;
                end
                MULT: begin
                    neg_r_q <= num_r_c[PW-1];
                    neg_i_q <= num_i_c[PW-1];
                    if (den_zero) begin
                        qr_q  <= '0;
                        qi_q  <= '0;
                        dbz_q <= 1'b1;
                    end
                end
                DIV: if (div_fin) begin
                    qr_q  <= QW'(q_full_r);
                    qi_q  <= QW'(q_full_i);
                    dbz_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == IDLE) && !rst;
    assign bus.out_valid   = state_q == DONE;
    assign bus.qr          = qr_q;
    assign bus.qi          = qi_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_complex_divider.sv
// Randomized self-checking bench for complex_divider against a wide-integer reference model.
module tb_complex_divider;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    complex_divider_if #(.W(W)) bus ();

    complex_divider #(.W(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Exact complex quotient via 128-bit signed arithmetic; SV '/' truncates toward zero.
    task automatic ref_model(input logic signed [31:0] a, b, c, e,
                             output logic signed [32:0] eqr, eqi, output logic edbz);
        logic signed [127:0] ra, rb, rc, re, nre, nim, den;
        ra = a; rb = b; rc = c; re = e;
        nre = ra * rc + rb * re;
        nim = rb * rc - ra * re;
        den = rc * rc + re * re;
        if (den == 0) begin
            eqr = '0; eqi = '0; edbz = 1'b1;
        end else begin
            nre = nre / den;
            nim = nim / den;
            eqr = nre[32:0];
            eqi = nim[32:0];
            edbz = 1'b0;
        end
    endtask

    // Called at a negedge; returns at a negedge right after the result handshake.
    task automatic run_op(input logic signed [31:0] a, b, c, e,
                          input int stall, input bit poke, input string tag);
        logic signed [32:0] eqr, eqi, hqr, hqi;
        logic edbz, hdbz;
        int cyc;
        bit ok;
        ref_model(a, b, c, e, eqr, eqi, edbz);
        check({tag, "_inrdy"}, bus.in_ready, 1);
        bus.nr = a; bus.ni = b; bus.dr = c; bus.di = e;
        bus.in_valid = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.in_valid = 1'b0;
            if (poke && cyc >= 3 && cyc <= 5) begin
                bus.in_valid = 1'b1;
                bus.nr = $urandom; bus.ni = $urandom; bus.dr = 1; bus.di = 0;
            end
            if (bus.out_valid) break;
        end
        bus.in_valid = 1'b0;
        check({tag, "_lat"}, cyc, edbz ? 2 : 67);
        check({tag, "_qr"}, bus.qr, eqr);
        check({tag, "_qi"}, bus.qi, eqi);
        check({tag, "_dbz"}, bus.div_by_zero, edbz);
        if (stall > 0) begin
            hqr = bus.qr; hqi = bus.qi; hdbz = bus.div_by_zero;
            ok = 1'b1;
            for (int s = 0; s < stall; s++) begin
                if (poke) begin
                    bus.in_valid = 1'b1;
                    bus.nr = $urandom; bus.dr = 2;
                end
                @(negedge clk);
                if (!bus.out_valid || bus.in_ready || bus.qr !== hqr ||
                    bus.qi !== hqi || bus.div_by_zero !== hdbz) ok = 1'b0;
            end
            bus.in_valid = 1'b0;
            check({tag, "_stall"}, ok, 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_ovlow"}, bus.out_valid, 0);
        check({tag, "_rdyback"}, bus.in_ready, 1);
    endtask

    initial begin
        logic signed [31:0] a, b, c, e;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.nr = '0; bus.ni = '0; bus.dr = '0; bus.di = '0;
        repeat (3) @(negedge clk);
        check("rst_inrdy", bus.in_ready, 0);
        check("rst_ov", bus.out_valid, 0);
        check("rst_qr", bus.qr, 0);
        check("rst_qi", bus.qi, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        rst = 1'b0;
        #1 check("rst_release_inrdy", bus.in_ready, 1);
        @(negedge clk);

        run_op(-5, 10, 1, 2, 0, 1'b0, "mulinv");
        run_op(7, 0, 2, 0, 0, 1'b0, "trunc_pos");
        run_op(-7, 0, 2, 0, 0, 1'b0, "trunc_neg");
        run_op(32'sh80000000, 32'sh80000000, -1, 0, 0, 1'b0, "extreme");
        run_op(5, 5, 0, 0, 3, 1'b1, "dbz");
        run_op(100, -37, 3, 5, 10, 1'b1, "backpr");
        run_op(-1000, 77, -7, 2, 0, 1'b0, "b2b");

        // Abort a division 20 cycles in with a one-cycle reset.
        bus.nr = 123456; bus.ni = -999; bus.dr = 7; bus.di = 3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ov", bus.out_valid, 0);
        check("midrst_inrdy", bus.in_ready, 0);
        check("midrst_qr", bus.qr, 0);
        check("midrst_dbz", bus.div_by_zero, 0);
        rst = 1'b0;
        #1 check("midrst_release", bus.in_ready, 1);
        @(negedge clk);
        run_op(12, 0, 3, 0, 0, 1'b0, "after_rst");

        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom; c = $urandom; e = $urandom;
            if (i % 2 == 1) begin
                c = int'($urandom_range(0, 16)) - 8;
                e = int'($urandom_range(0, 16)) - 8;
            end
            if (i % 5 == 2) begin
                a = int'($urandom_range(0, 2000)) - 1000;
                b = int'($urandom_range(0, 2000)) - 1000;
                c = int'($urandom_range(0, 40)) - 20;
                e = int'($urandom_range(0, 40)) - 20;
            end
            run_op(a, b, c, e, (i % 4 == 0) ? 3 : 0, i[0], $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
